// File: rtl/ttl_74193_sync.sv
// 74LS193 4-bit up/down counter re-timed into a single clock domain.
// Optional macro TTL74193_REG_TC_EN registers the terminal-count outputs.
module ttl_74193_sync #(
   parameter logic [3:0] RESET_VALUE = 4'h0
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       CLR,
   input  logic       PLn,
   input  logic [3:0] D,
   input  logic       UP,
   input  logic       DOWN,
   output logic [3:0] Q,
   output logic       TCUn,
   output logic       TCDn
);

   logic [3:0] cnt_q, cnt_d;
   logic       up_q, up_d;
   logic       dn_q, dn_d;
   logic       up_rise, dn_rise;

   always_comb begin
      up_d    = UP;
      dn_d    = DOWN;
      cnt_d   = cnt_q;
      up_rise = UP & ~up_q;
      dn_rise = DOWN & ~dn_q;
      if (CLR) begin
         cnt_d = '0;
      end else if (!PLn) begin
         cnt_d = D;
      end else if (up_rise && !dn_rise && DOWN) begin
         cnt_d = cnt_q + 4'd1;
      end else if (dn_rise && !up_rise && UP) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   // Trackers reset high so inputs held high across reset release give no edge.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cnt_q <= RESET_VALUE;
         up_q  <= 1'b1;
         dn_q  <= 1'b1;
      end else begin
         cnt_q <= cnt_d;
         up_q  <= up_d;
         dn_q  <= dn_d;
      end
   end

   assign Q = cnt_q;

`ifdef TTL74193_REG_TC_EN
   logic tcu_q, tcu_d;
   logic tcd_q, tcd_d;

   always_comb begin
      tcu_d = ~((cnt_d == 4'hF) & ~UP);
      tcd_d = ~((cnt_d == 4'h0) & ~DOWN);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         tcu_q <= 1'b1;
         tcd_q <= 1'b1;
      end else begin
         tcu_q <= tcu_d;
         tcd_q <= tcd_d;
      end
   end

   assign TCUn = tcu_q;
   assign TCDn = tcd_q;
`else
   assign TCUn = ~((cnt_q == 4'hF) & ~UP);
   assign TCDn = ~((cnt_q == 4'h0) & ~DOWN);
`endif

endmodule

// File: tb/tb_ttl_74193_sync.sv
// Self-checking bench for ttl_74193_sync: directed literal checks plus
// randomized stimulus against an arithmetic reference model.
module tb_ttl_74193_sync;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       CLR = 1'b0;
   logic       PLn = 1'b1;
   logic [3:0] D = '0;
   logic       UP = 1'b1;
   logic       DOWN = 1'b1;
   logic [3:0] Q;
   logic       TCUn, TCDn;

   int total = 0;
   int bad = 0;

   ttl_74193_sync #(.RESET_VALUE(4'h0)) dut (
      .Clk(Clk), .Reset(Reset), .CLR(CLR), .PLn(PLn), .D(D),
      .UP(UP), .DOWN(DOWN), .Q(Q), .TCUn(TCUn), .TCDn(TCDn)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: counter as an integer mod 16, previous input levels as bits.
   int m_q;
   bit m_pu, m_pd;
   bit m_tcu, m_tcd;

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         m_q = 0; m_pu = 1; m_pd = 1; m_tcu = 1; m_tcd = 1;
      end else begin
         int  nq;
         bit  ur, dr;
         nq = m_q;
         ur = UP && !m_pu;
         dr = DOWN && !m_pd;
         if (CLR) nq = 0;
         else if (!PLn) nq = int'(D);
         else if (ur && !dr && DOWN) nq = (m_q + 1) % 16;
         else if (dr && !ur && UP) nq = (m_q + 15) % 16;
         m_tcu = !(nq == 15 && !UP);
         m_tcd = !(nq == 0 && !DOWN);
         m_q = nq;
         m_pu = UP;
         m_pd = DOWN;
      end
   end

   always @(negedge Clk) begin
      if (!Reset) begin
         chk("model_q", int'(Q), m_q);
`ifdef TTL74193_REG_TC_EN
         chk("model_tcun", int'(TCUn), int'(m_tcu));
         chk("model_tcdn", int'(TCDn), int'(m_tcd));
`else
         chk("model_tcun", int'(TCUn), (m_q == 15 && !UP) ? 0 : 1);
         chk("model_tcdn", int'(TCDn), (m_q == 0 && !DOWN) ? 0 : 1);
`endif
      end
   end

   task automatic cyc(input logic u, input logic dn, input logic clr = 1'b0,
                      input logic pln = 1'b1, input logic [3:0] d = 4'h0);
      UP = u; DOWN = dn; CLR = clr; PLn = pln; D = d;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int falls;
      bit prev_tcu;
      // Reset with inputs high, release: no count.
      #12;
      chk("reset_q", int'(Q), 0);
      chk("reset_tcun", int'(TCUn), 1);
      chk("reset_tcdn", int'(TCDn), 1);
      Reset = 1'b0;
      cyc(1, 1);
      chk("release_no_count", int'(Q), 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1);
         cyc(1, 1);
      end
      chk("up_three", int'(Q), 3);

      // Load E, count up through F to 0.
      cyc(1, 1, 0, 0, 4'hE);
      chk("load_e", int'(Q), 14);
      cyc(0, 1);
      cyc(1, 1);
      chk("up_to_f", int'(Q), 15);
      cyc(0, 1);
      cyc(0, 1);
      chk("tcun_low_at_f", int'(TCUn), 0);
      cyc(1, 1);
      chk("wrap_to_0", int'(Q), 0);
      chk("tcun_high_after_wrap", int'(TCUn), 1);

      // Count down from 1 through 0 to F.
      cyc(1, 1, 0, 0, 4'h1);
      cyc(1, 0);
      cyc(1, 1);
      chk("down_to_0", int'(Q), 0);
      cyc(1, 0);
      cyc(1, 0);
      chk("tcdn_low_at_0", int'(TCDn), 0);
      cyc(1, 1);
      chk("down_wrap_f", int'(Q), 15);
      chk("tcdn_high_after_wrap", int'(TCDn), 1);

      // Clear beats load beats count.
      cyc(0, 1);
      cyc(1, 1, 1, 0, 4'h5);
      chk("clr_priority", int'(Q), 0);
      cyc(1, 1, 0, 0, 4'h5);
      chk("load_over_hold", int'(Q), 5);
      cyc(1, 1);
      chk("no_count_after_load", int'(Q), 5);

      // Simultaneous edges and illegal single edge both hold.
      cyc(0, 0);
      cyc(1, 1);
      chk("both_rise_hold", int'(Q), 5);
      cyc(0, 0);
      cyc(1, 0);
      chk("up_rise_down_low_hold", int'(Q), 5);

      // Two full wraps: a J=K=1 toggle stage on TCUn falls flips twice.
      cyc(1, 1, 0, 0, 4'h0);
      falls = 0;
      prev_tcu = TCUn;
      for (int i = 0; i < 32; i++) begin
         cyc(0, 1);
         if (prev_tcu && !TCUn) falls++;
         prev_tcu = TCUn;
         cyc(1, 1);
         if (prev_tcu && !TCUn) falls++;
         prev_tcu = TCUn;
      end
      chk("jk_toggles", falls, 2);
      chk("after_two_wraps", int'(Q), 0);

      // Randomized run with occasional clear, load and async reset pulses.
      for (int i = 0; i < 2000; i++) begin
         UP   = 1'($urandom_range(0, 1));
         DOWN = 1'($urandom_range(0, 1));
         CLR  = ($urandom_range(0, 31) == 0);
         PLn  = ($urandom_range(0, 15) != 0);
         D    = 4'($urandom);
         if ($urandom_range(0, 99) == 0) begin
            #1 Reset = 1'b1;
            #1 Reset = 1'b0;
         end
         @(posedge Clk);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
